fft_band_accum: RTL and testbench
=================================

FFT_BAND_ACCUM -- requirements
Module: fft_band_accum

Interface
REQ-001 SHALL have parameter N_POINTS, default 512, FFT frame length in complex samples.
REQ-002 SHALL have parameter N_BANDS, default 16, number of output bands covering bins 0..N_POINTS/2-1.
REQ-003 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have ports in_valid input 1, in_ready output 1; beat transfers when both are high at a clk edge.
REQ-006 SHALL have ports in_real and in_imag, input, 16 each, signed two's-complement FFT output bin.
REQ-007 SHALL have port in_last, input, 1, marks final bin of a frame.
REQ-008 SHALL have ports out_valid output 1, out_ready input 1; band transfers when both are high.
REQ-009 SHALL have ports out_band output 4, out_mag output 20, out_last output 1 (set on band N_BANDS-1).
REQ-010 SHALL have port frame_err, output, 1, sticky frame-length error flag.

Function
REQ-011 SHALL compute per-bin magnitude as max(|re|,|im|) + min(|re|,|im|)>>1, 16-bit unsigned; |-32768| = 32768.
REQ-012 SHALL register magnitude in a 2-stage pipeline (abs/compare, add); accumulate 2 cycles after acceptance.
REQ-013 SHALL implement states IDLE, ACCUM, FLUSH, DRAIN.
REQ-014 IDLE: in_ready=1; first accepted beat is bin 0 and moves to ACCUM.
REQ-015 ACCUM: in_ready=1; bin counter increments per accepted beat.
REQ-016 Bin k < N_POINTS/2 SHALL add into accumulator k/(N_POINTS/(2*N_BANDS)); bins >= N_POINTS/2 are accepted and discarded.
REQ-017 Accumulators SHALL be 20-bit; no overflow is possible at the default parameters (16 x 49152 < 2^20).
REQ-018 Accepted beat with in_last=1 SHALL move to FLUSH.
REQ-019 in_last at a bin index other than N_POINTS-1 SHALL set frame_err and end the frame.
REQ-020 Bin N_POINTS-1 without in_last SHALL set frame_err and end the frame.
REQ-021 FLUSH: in_ready=0 for exactly 2 cycles to drain the pipeline, then DRAIN.
REQ-022 DRAIN: in_ready=0; out_valid=1; bands emitted in order 0..N_BANDS-1, advancing on out_valid&&out_ready.
REQ-023 out_band/out_mag/out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-024 After the final band handshake, SHALL clear all accumulators and the bin counter and return to IDLE the next cycle.
REQ-025 in_valid=0 mid-frame SHALL stall counting with no loss; no timeout.

Reset
REQ-026 rst SHALL force IDLE, in_ready=1, out_valid=0, out_band=0, out_mag=0, out_last=0, frame_err=0, accumulators/counter/pipeline cleared.
REQ-027 rst mid-frame or mid-DRAIN SHALL discard the partial frame; the next beat after reset is bin 0.
REQ-028 frame_err SHALL clear only on rst.

Configuration
REQ-029 Macro FFT_BAND_LOG_SCALE_EN defined: out_mag = {11'b0, p[4:0], m[3:0]}, where p = leading-one index of the accumulator and m = the 4 bits below it (zero-filled); accumulator 0 -> 0.
REQ-030 Macro undefined: out_mag = linear accumulator value.

Structure
REQ-031 Package fft_pkg SHALL hold N_POINTS/N_BANDS defaults, SAMPLE_W=16, MAG_W=16, ACC_W=20, and the state enum type.
REQ-032 Magnitude pipeline SHALL be sub-module fft_mag_approx (in: re, im, valid; out: mag, valid).

Verification
REQ-033 512 beats re=100, im=0, in_last on 511, out_ready=1 -> 16 bands, out_mag=1600 each, out_last on band 15, frame_err=0.
REQ-034 Bin 0 = (-32768,-32768), others 0 -> band0 out_mag=49152, bands 1..15 = 0.
REQ-035 Bins 256..511 = (30000,30000), bins 0..255 = 0 -> all bands 0 (upper half discarded).
REQ-036 in_last at bin 300 -> frame_err=1, FLUSH then DRAIN; next frame accumulates normally from bin 0.
REQ-037 out_ready toggled 1-of-3 cycles during DRAIN -> outputs stable while stalled; band order 0..15 intact; in_ready=0 throughout.
REQ-038 rst asserted at bin 200 -> all outputs at reset values; following full frame gives REQ-033 results.

Source files
------------

// File: rtl/fft_pkg.sv
// fft_pkg: shared widths, parameter defaults, FSM state type and log-scale helper for fft_band_accum.
package fft_pkg;
  localparam int DEF_N_POINTS = 512;
  localparam int DEF_N_BANDS = 16;
  localparam int SAMPLE_W = 16;
  localparam int MAG_W = 16;
  localparam int ACC_W = 20;
  typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, DRAIN} state_t;
  // Leading-one position in [8:4], the next four bits below it in [3:0].
  function automatic logic [ACC_W-1:0] log_scale(input logic [ACC_W-1:0] a);
    logic [4:0] p;
    logic [ACC_W-1:0] s;
    p = '0;
    for (int i = 0; i < ACC_W; i++) if (a[i]) p = 5'(i);
    s = a << (5'(ACC_W - 1) - p);
    return (a == '0) ? '0 : {11'b0, p, 4'(s >> (ACC_W - 5))};
  endfunction
endpackage

// File: rtl/fft_mag_approx.sv
// fft_mag_approx: two-stage alpha-max-plus-beta-min magnitude, max(|re|,|im|) + min(|re|,|im|)/2.
module fft_mag_approx
  import fft_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [SAMPLE_W-1:0] i_re,
  input  logic signed [SAMPLE_W-1:0] i_im,
  input  logic                       i_valid,
  output logic        [MAG_W-1:0]    o_mag,
  output logic                       o_valid
);
  logic [SAMPLE_W:0] w_re_x, w_im_x, w_are, w_aim;
  logic [MAG_W-1:0] r_mx, r_mn;
  logic r_v1;
  // Sign-extend by one bit so |-32768| stays representable.
  assign w_re_x = {i_re[SAMPLE_W-1], i_re};
  assign w_im_x = {i_im[SAMPLE_W-1], i_im};
  assign w_are = w_re_x[SAMPLE_W] ? (~w_re_x + 1'b1) : w_re_x;
  assign w_aim = w_im_x[SAMPLE_W] ? (~w_im_x + 1'b1) : w_im_x;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mx <= '0;
      r_mn <= '0;
      r_v1 <= 1'b0;
      o_mag <= '0;
      o_valid <= 1'b0;
    end else begin
      r_mx <= MAG_W'((w_are > w_aim) ? w_are : w_aim);
      r_mn <= MAG_W'((w_are > w_aim) ? w_aim : w_are);
      r_v1 <= i_valid;
      o_mag <= r_mx + {1'b0, r_mn[MAG_W-1:1]};
      o_valid <= r_v1;
    end
  end
endmodule

// File: rtl/fft_band_accum.sv
// fft_band_accum: sums per-bin FFT magnitudes into bands and streams them out per frame.
// Define FFT_BAND_LOG_SCALE_EN to emit a log-compressed magnitude instead of the linear sum.
module fft_band_accum
  import fft_pkg::*;
#(
  parameter int N_POINTS = DEF_N_POINTS,
  parameter int N_BANDS = DEF_N_BANDS
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [SAMPLE_W-1:0] in_real,
  input  logic signed [SAMPLE_W-1:0] in_imag,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic        [3:0]          out_band,
  output logic        [ACC_W-1:0]    out_mag,
  output logic                       out_last,
  output logic                       frame_err
);
  localparam int CW = $clog2(N_POINTS);
  localparam int HALF = N_POINTS / 2;
  localparam int BPB = N_POINTS / (2 * N_BANDS);
  state_t r_state;
  logic [CW-1:0] r_cnt;
  logic r_flush, r_err, r_keep1, r_keep2;
  logic [3:0] r_band, r_bidx1, r_bidx2;
  logic [ACC_W-1:0] r_acc [N_BANDS];
  logic w_acc_in, w_at_top, w_end, w_out_hs, w_mag_v;
  logic [3:0] w_bidx;
  logic [MAG_W-1:0] w_mag;
  logic [ACC_W-1:0] w_sel;
  assign in_ready = (r_state == IDLE) || (r_state == ACCUM);
  assign w_acc_in = in_valid && in_ready;
  assign w_at_top = r_cnt == CW'(N_POINTS - 1);
  assign w_end = in_last || w_at_top;
  assign w_bidx = 4'(int'(r_cnt) / BPB);
  assign out_valid = r_state == DRAIN;
  assign out_band = r_band;
  assign out_last = out_valid && (r_band == 4'(N_BANDS - 1));
  assign w_out_hs = out_valid && out_ready;
  assign w_sel = r_acc[r_band];
  assign frame_err = r_err;
`ifdef FFT_BAND_LOG_SCALE_EN
  assign out_mag = log_scale(w_sel);
`else
  assign out_mag = w_sel;
`endif
  fft_mag_approx u_mag (
    .clk(clk),
    .rst(rst),
    .i_re(in_real),
    .i_im(in_imag),
    .i_valid(w_acc_in),
    .o_mag(w_mag),
    .o_valid(w_mag_v)
  );
  // Band tag travels beside the magnitude pipeline; upper-half bins carry keep=0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_flush <= 1'b0;
      r_err <= 1'b0;
      r_band <= '0;
      r_keep1 <= 1'b0;
      r_keep2 <= 1'b0;
      r_bidx1 <= '0;
      r_bidx2 <= '0;
      for (int i = 0; i < N_BANDS; i++) r_acc[i] <= '0;
    end else begin
      r_keep1 <= w_acc_in && (int'(r_cnt) < HALF);
      r_bidx1 <= w_bidx;
      r_keep2 <= r_keep1;
      r_bidx2 <= r_bidx1;
      if (w_mag_v && r_keep2) r_acc[r_bidx2] <= r_acc[r_bidx2] + ACC_W'(w_mag);
      case (r_state)
        IDLE, ACCUM: if (w_acc_in) begin
          r_cnt <= r_cnt + 1'b1;
          r_state <= w_end ? FLUSH : ACCUM;
          if (in_last != w_at_top) r_err <= 1'b1;
        end
        FLUSH: begin
          r_flush <= !r_flush;
          if (r_flush) r_state <= DRAIN;
        end
        DRAIN: if (w_out_hs) begin
          r_band <= r_band + 1'b1;
          if (out_last) begin
            r_state <= IDLE;
            r_band <= '0;
            r_cnt <= '0;
            for (int i = 0; i < N_BANDS; i++) r_acc[i] <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fft_band_accum.sv
// tb_fft_band_accum: randomized frames checked against a per-band sum model built from bin arithmetic.
module tb_fft_band_accum;
  localparam int NP = 512;
  localparam int NB = 16;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, in_last, out_valid, out_ready, out_last, frame_err;
  logic signed [15:0] in_real, in_imag;
  logic [3:0] out_band;
  logic [19:0] out_mag;
  int errors = 0;
  int checks = 0;
  int fre[NP];
  int fim[NP];
  int exp_mag[NB];
  bit exp_err;

  fft_band_accum dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_real(in_real), .in_imag(in_imag), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_band(out_band),
    .out_mag(out_mag), .out_last(out_last), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  function automatic int ref_mag(input int re, input int im);
    int ar, ai;
    ar = re < 0 ? -re : re;
    ai = im < 0 ? -im : im;
    return (ar > ai) ? ar + ai / 2 : ai + ar / 2;
  endfunction

  function automatic int rnd_sample();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic fill(input int re, input int im);
    for (int k = 0; k < NP; k++) begin
      fre[k] = re;
      fim[k] = im;
    end
  endtask

  task automatic send_frame(input int nb, input int last_idx, input bit gaps);
    for (int b = 0; b < NB; b++) exp_mag[b] = 0;
    for (int k = 0; k < nb; k++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      in_valid = 1'b1;
      in_real = 16'(fre[k]);
      in_imag = 16'(fim[k]);
      in_last = (k == last_idx);
      for (int t = 0; t < 8 && !in_ready; t++) @(negedge clk);
      @(negedge clk);
      if (k < NP / 2) exp_mag[k / (NP / (2 * NB))] += ref_mag(fre[k], fim[k]);
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    if (last_idx != NP - 1) exp_err = 1'b1;
  endtask

  task automatic check_drain(input string name, input bit stall);
    int w;
    logic [3:0] sb;
    logic [19:0] sm;
    logic sl;
    w = 0;
    while (!out_valid && w < 20) begin
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s flush_ready got=%b want=0", name, in_ready);
      end
      w++;
      @(negedge clk);
    end
    checks++;
    if (w !== 2) begin
      errors++;
      $display("FAIL %s flush_cycles got=%0d want=2", name, w);
      return;
    end
    for (int b = 0; b < NB; b++) begin
      if (stall) begin
        out_ready = 1'b0;
        sb = out_band;
        sm = out_mag;
        sl = out_last;
        repeat (2) @(negedge clk);
        checks++;
        if (out_band !== sb || out_mag !== sm || out_last !== sl || out_valid !== 1'b1 || in_ready !== 1'b0) begin
          errors++;
          $display("FAIL %s stall_hold band=%0d mag=%0d last=%b v=%b rdy=%b want band=%0d mag=%0d last=%b v=1 rdy=0",
                   name, out_band, out_mag, out_last, out_valid, in_ready, sb, sm, sl);
        end
      end
      out_ready = 1'b1;
      checks++;
      if (out_band !== 4'(b) || out_mag !== 20'(exp_mag[b]) || out_last !== (b == NB - 1) || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s band%0d got band=%0d mag=%0d last=%b v=%b rdy=%b want band=%0d mag=%0d last=%b v=1 rdy=0",
                 name, b, out_band, out_mag, out_last, out_valid, in_ready, b, exp_mag[b], b == NB - 1);
      end
      @(negedge clk);
    end
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s back_to_idle got rdy=%b v=%b want rdy=1 v=0", name, in_ready, out_valid);
    end
    checks++;
    if (frame_err !== exp_err) begin
      errors++;
      $display("FAIL %s frame_err got=%b want=%b", name, frame_err, exp_err);
    end
  endtask

  task automatic check_reset_vals(input string name);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL %s rst_flags got rdy=%b v=%b err=%b want 1 0 0", name, in_ready, out_valid, frame_err);
    end
    checks++;
    if (out_band !== 4'd0 || out_mag !== 20'd0 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL %s rst_outs got band=%0d mag=%0d last=%b want 0 0 0", name, out_band, out_mag, out_last);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_last = 1'b0;
    in_real = '0;
    in_imag = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    exp_err = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_constant();
    fill(100, 0);
    send_frame(NP, NP - 1, 1'b0);
    check_drain("constant", 1'b0);
  endtask

  task automatic test_min_corner();
    fill(0, 0);
    fre[0] = -32768;
    fim[0] = -32768;
    send_frame(NP, NP - 1, 1'b0);
    check_drain("min_corner", 1'b0);
  endtask

  task automatic test_upper_discard();
    fill(0, 0);
    for (int k = NP / 2; k < NP; k++) begin
      fre[k] = 30000;
      fim[k] = 30000;
    end
    send_frame(NP, NP - 1, 1'b1);
    check_drain("upper_discard", 1'b0);
  endtask

  task automatic test_short_frame();
    fill(100, 0);
    send_frame(301, 300, 1'b0);
    check_drain("short_frame", 1'b0);
    for (int k = 0; k < NP; k++) fre[k] = k % 7 - 3;
    send_frame(NP, NP - 1, 1'b0);
    check_drain("after_short", 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < NP; k++) begin
      fre[k] = rnd_sample();
      fim[k] = rnd_sample();
    end
    send_frame(NP, NP - 1, 1'b0);
    check_drain("backpressure", 1'b1);
  endtask

  task automatic test_random();
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < NP; k++) begin
        fre[k] = ($urandom_range(0, 7) == 0) ? -32768 : rnd_sample();
        fim[k] = rnd_sample();
      end
      send_frame(NP, NP - 1, 1'b1);
      check_drain("random", f[0]);
    end
  endtask

  task automatic test_mid_reset();
    int w;
    fill(100, 0);
    send_frame(200, -1, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_vals("mid_frame_rst");
    exp_err = 1'b0;
    send_frame(NP, NP - 1, 1'b0);
    check_drain("after_frame_rst", 1'b0);
    fill(500, -700);
    send_frame(NP, NP - 1, 1'b0);
    w = 0;
    while (!out_valid && w < 20) begin
      w++;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_vals("mid_drain_rst");
    fill(100, 0);
    send_frame(NP, NP - 1, 1'b0);
    check_drain("after_drain_rst", 1'b0);
  endtask

  initial begin
    test_reset();
    test_constant();
    test_min_corner();
    test_upper_discard();
    test_short_frame();
    test_back_to_back();
    test_random();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
